// File: rtl/id_stage_pipelined.sv
// Decode stage with integrated ID/EX pipeline register.
// Holds the condition check, control decode, a register file with
// write-through bypass, and stall/flush/freeze handling. Hazard source
// indices (src1/src2/two_src) stay combinational for the hazard unit.
module id_stage_pipelined #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              id_valid,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              hazard,
  input  logic              flush,
  input  logic              freeze,
  input  logic [3:0]        sr,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_r,
  output logic              ex_mem_w,
  output logic              ex_branch,
  output logic              ex_s,
  output logic [3:0]        ex_cmd,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic              ex_imm,
  output logic [11:0]       ex_shift,
  output logic [DATA_W-1:0] ex_simm,
  output logic [3:0]        ex_dest,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2,
  output logic [DATA_W-1:0] ex_pc
);

  localparam logic [4:0] NUM_REGS_C = 5'(NUM_REGS);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r;
    logic              mem_w;
    logic              branch;
    logic              s;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift;
    logic [DATA_W-1:0] simm;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [DATA_W-1:0] pc;
  } idex_t;

  // Condition evaluation against status flags {N,Z,C,V}.
  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_check = z;
      4'b0001: cond_check = ~z;
      4'b0010: cond_check = cf;
      4'b0011: cond_check = ~cf;
      4'b0100: cond_check = n;
      4'b0101: cond_check = ~n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = ~v;
      4'b1000: cond_check = cf & ~z;
      4'b1001: cond_check = ~cf | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = ~z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  // Instruction fields.
  logic [3:0]  cond_s;
  logic [1:0]  mode_s;
  logic        i_bit_s;
  logic [3:0]  opcode_s;
  logic        s_bit_s;
  logic [3:0]  rn_s;
  logic [3:0]  rd_s;
  logic [3:0]  rm_s;
  logic [11:0] shift_s;
  logic [23:0] imm24_s;

  assign cond_s   = instr[31:28];
  assign mode_s   = instr[27:26];
  assign i_bit_s  = instr[25];
  assign opcode_s = instr[24:21];
  assign s_bit_s  = instr[20];
  assign rn_s     = instr[19:16];
  assign rd_s     = instr[15:12];
  assign rm_s     = instr[3:0];
  assign shift_s  = instr[11:0];
  assign imm24_s  = instr[23:0];

  // Decoded controls.
  logic       ctl_wb_s;
  logic       ctl_mem_r_s;
  logic       ctl_mem_w_s;
  logic       ctl_branch_s;
  logic       ctl_s_s;
  logic [3:0] ctl_cmd_s;
  logic       is_store_s;
  logic       bubble_s;

  // Control decode from mode/opcode/S.
  always_comb begin
    ctl_wb_s     = 1'b0;
    ctl_mem_r_s  = 1'b0;
    ctl_mem_w_s  = 1'b0;
    ctl_branch_s = 1'b0;
    ctl_s_s      = 1'b0;
    ctl_cmd_s    = 4'b0000;
    case (mode_s)
      2'b00: begin
        case (opcode_s)
          4'b1101: begin ctl_cmd_s = 4'b0001; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b1111: begin ctl_cmd_s = 4'b1001; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b0100: begin ctl_cmd_s = 4'b0010; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b0101: begin ctl_cmd_s = 4'b0011; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b0010: begin ctl_cmd_s = 4'b0100; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b0110: begin ctl_cmd_s = 4'b0101; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b0000: begin ctl_cmd_s = 4'b0110; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b1100: begin ctl_cmd_s = 4'b0111; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b0001: begin ctl_cmd_s = 4'b1000; ctl_wb_s = 1'b1; ctl_s_s = s_bit_s; end
          4'b1010: begin ctl_cmd_s = 4'b0100; ctl_s_s = s_bit_s; end
          4'b1000: begin ctl_cmd_s = 4'b0110; ctl_s_s = s_bit_s; end
          default: begin ctl_cmd_s = 4'b0000; end
        endcase
      end
      2'b01: begin
        ctl_cmd_s = 4'b0010;
        if (s_bit_s) begin
          ctl_mem_r_s = 1'b1;
          ctl_wb_s    = 1'b1;
        end else begin
          ctl_mem_w_s = 1'b1;
        end
      end
      2'b10: begin
        ctl_branch_s = 1'b1;
      end
      default: begin
        ctl_cmd_s = 4'b0000;
      end
    endcase
  end

  assign is_store_s = (mode_s == 2'b01) && !s_bit_s;
  assign src1       = rn_s;
  assign src2       = is_store_s ? rd_s : rm_s;
  assign two_src    = ~i_bit_s | is_store_s;
  assign bubble_s   = ~id_valid | ~cond_check(cond_s, sr) | hazard;

  // Register file state; entries at or above NUM_REGS are never written.
  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] rf_d [16];
  logic              wb_ok_s;
  logic [DATA_W-1:0] val_rn_s;
  logic [DATA_W-1:0] val_rm_s;

  assign wb_ok_s = wb_en && ({1'b0, wb_dest} < NUM_REGS_C);

  // Register file next state: single write port.
  always_comb begin
    rf_d = rf_q;
    if (wb_ok_s) begin
      rf_d[wb_dest] = wb_result;
    end else begin
      rf_d = rf_q;
    end
  end

  // Combinational reads with write-through bypass; out-of-range reads give 0.
  always_comb begin
    val_rn_s = '0;
    val_rm_s = '0;
    if ({1'b0, rn_s} >= NUM_REGS_C) begin
      val_rn_s = '0;
    end else if (wb_ok_s && (wb_dest == rn_s)) begin
      val_rn_s = wb_result;
    end else begin
      val_rn_s = rf_q[rn_s];
    end
    if ({1'b0, src2} >= NUM_REGS_C) begin
      val_rm_s = '0;
    end else if (wb_ok_s && (wb_dest == src2)) begin
      val_rm_s = wb_result;
    end else begin
      val_rm_s = rf_q[src2];
    end
  end

  // ID/EX register.
  idex_t idex_q;
  idex_t idex_d;
  idex_t fresh_s;
  idex_t bubble_ld_s;

  // ID/EX next state: flush > freeze > bubble > normal load.
  always_comb begin
    fresh_s        = '0;
    fresh_s.valid  = 1'b1;
    fresh_s.wb_en  = ctl_wb_s;
    fresh_s.mem_r  = ctl_mem_r_s;
    fresh_s.mem_w  = ctl_mem_w_s;
    fresh_s.branch = ctl_branch_s;
    fresh_s.s      = ctl_s_s;
    fresh_s.cmd    = ctl_cmd_s;
    fresh_s.val_rn = val_rn_s;
    fresh_s.val_rm = val_rm_s;
    fresh_s.imm    = i_bit_s;
    fresh_s.shift  = shift_s;
    fresh_s.simm   = DATA_W'($signed(imm24_s));
    fresh_s.dest   = rd_s;
    fresh_s.src1   = rn_s;
    fresh_s.src2   = src2;
    fresh_s.pc     = pc_in;

    bubble_ld_s        = fresh_s;
    bubble_ld_s.valid  = 1'b0;
    bubble_ld_s.wb_en  = 1'b0;
    bubble_ld_s.mem_r  = 1'b0;
    bubble_ld_s.mem_w  = 1'b0;
    bubble_ld_s.branch = 1'b0;
    bubble_ld_s.s      = 1'b0;
    bubble_ld_s.cmd    = 4'b0000;

    idex_d = idex_q;
    if (flush) begin
      idex_d = bubble_ld_s;
    end else if (freeze) begin
      idex_d = idex_q;
    end else if (bubble_s) begin
      idex_d = bubble_ld_s;
    end else begin
      idex_d = fresh_s;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
      rf_q   <= '{default: '0};
    end else begin
      idex_q <= idex_d;
      rf_q   <= rf_d;
    end
  end

  assign ex_valid  = idex_q.valid;
  assign ex_wb_en  = idex_q.wb_en;
  assign ex_mem_r  = idex_q.mem_r;
  assign ex_mem_w  = idex_q.mem_w;
  assign ex_branch = idex_q.branch;
  assign ex_s      = idex_q.s;
  assign ex_cmd    = idex_q.cmd;
  assign ex_val_rn = idex_q.val_rn;
  assign ex_val_rm = idex_q.val_rm;
  assign ex_imm    = idex_q.imm;
  assign ex_shift  = idex_q.shift;
  assign ex_simm   = idex_q.simm;
  assign ex_dest   = idex_q.dest;
  assign ex_src1   = idex_q.src1;
  assign ex_src2   = idex_q.src2;
  assign ex_pc     = idex_q.pc;

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Parametrised decode stage with an integrated ID/EX pipeline register. It takes the IF-registered instruction and produces the operand and control bundle for EX one cycle later. Internally it holds the condition check, the control decode, a register file with write-through bypass, and the stall/flush/freeze handling. Hazard source indices stay combinational for the hazard unit.

Parameters:
DATA_W, 32, datapath width of register values, PC and sign-extended immediate; must be >= 24
NUM_REGS, 16, implemented registers (1..16); indices >= NUM_REGS read 0 and ignore writes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
instr  in  32  instruction from IF register: cond[31:28] mode[27:26] I[25] opcode[24:21] S[20] Rn[19:16] Rd[15:12] shift[11:0] imm24[23:0]
pc_in  in  DATA_W  PC+4 of instr
id_valid  in  1  instr is a real instruction (0 = bubble from IF)
wb_en  in  1  write-back enable
wb_dest  in  4  write-back register
wb_result  in  DATA_W  write-back data
hazard  in  1  hazard unit stall request
flush  in  1  branch taken in EX; squash ID
freeze  in  1  hold ID/EX contents (memory wait)
sr  in  4  status {N,Z,C,V}
src1  out  4  Rn (combinational)
src2  out  4  Rd if decoded store, else instr[3:0] (combinational)
two_src  out  1  ~I | decoded store (combinational)
ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch, ex_s  out  1 each  registered controls
ex_cmd  out  4  registered ALU command
ex_val_rn, ex_val_rm  out  DATA_W  registered operands (post-bypass)
ex_imm  out  1  registered I bit
ex_shift  out  12  registered shift operand
ex_simm  out  DATA_W  registered sign-extended imm24
ex_dest  out  4  registered Rd
ex_src1, ex_src2  out  4 each  registered sources (for forwarding)
ex_pc  out  DATA_W  registered pc_in

Behaviour:
- Reset: all ex_* outputs are 0 and all registers are 0. Reset overrides every other input in the same cycle.
- Decode, mode 00, data-processing:
  - Commands: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000; wb=1.
  - CMP 1010->0100 and TST 1000->0110 set wb=0.
  - Undefined opcode: all controls 0.
- Decode, other modes:
  - mode 01, S=1 (LDR): cmd 0010, mem_r=1, wb=1.
  - mode 01, S=0 (STR): cmd 0010, mem_w=1.
  - mode 10 (B): branch=1, cmd 0000.
  - mode 11: all controls 0.
- s output: equals S for mode 00; 0 otherwise.
- Condition: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
- Bubble condition: ~id_valid | ~cond_pass | hazard. On a bubble, ex_valid and wb_en/mem_r/mem_w/branch/s/cmd load 0. Data fields (operands, dest, srcs, pc, imm fields) still load, so they are don't-care.
- Register file:
  - Synchronous write at posedge when wb_en and wb_dest < NUM_REGS.
  - Reads are combinational.
  - Write-through bypass: if wb_en and wb_dest equals a read index (< NUM_REGS), that read returns wb_result in the same cycle.
- Sign extension: ex_simm = imm24 sign-extended to DATA_W, with no shift.
- Latency: one cycle from instr to ex_* outputs.
- Per-cycle priority: rst > flush (ID/EX loads bubble) > freeze (ID/EX holds every field) > bubble condition > normal load.
  - The register-file write still occurs during freeze and flush.
- hazard and flush asserted together produce a bubble. Frozen contents reappear unchanged once freeze drops.
- The src1/src2/two_src outputs are never gated by cond, hazard or flush.

Test Plan:
1. Reset, then ADD R1,R2,R3 (0xE0821003) with R2=5, R3=7 preloaded via WB -> next cycle ex_valid=1, ex_cmd=0010, ex_wb_en=1, ex_val_rn=5, ex_val_rm=7, ex_dest=1.
2. Bypass: same cycle wb_en=1, wb_dest=2, wb_result=0x99 while decoding ADD above -> ex_val_rn=0x99.
3. Condition sweep: BEQ with sr=0000 -> ex_valid=0, ex_branch=0; with sr=0100 -> ex_branch=1, ex_simm sign-extended (imm24 0xFFFFFE -> 0xFFFFFFFE).
4. STR R4,[R5] (mode 01, S=0, I=1) -> two_src=1, src2=4, ex_mem_w=1, ex_wb_en=0.
5. LDR in ID/EX, assert freeze 3 cycles with a new instr and hazard=1 -> ex_* unchanged; freeze low -> the new instruction loads as a bubble (hazard=1).
6. flush=1 with freeze=1 and valid MOV -> ex_valid=0. NUM_REGS=8 build: reads of R12 return 0, and WB writes to R12 are ignored.
